pack_s3_sched: RTL and testbench

PACK_S3_SCHED -- requirements
Module: pack_s3_sched

---
 rtl/pack_s3_sched.sv | 155 +++++++++++++++
 tb/tb_pack_s3_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_s3_sched.sv
// Two-requester scheduler that streams 5-trit groups through one shared
// trit5-to-byte converter and emits ITER_BOUND packed bytes per granted job.
module pack_s3_sched #(
    parameter int ITER_BOUND = 140,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [9:0] grp0,
    input  logic [9:0] grp1,
    output logic [1:0] grp_rd,
    output logic [9:0] conv_a,
    output logic       conv_start,
    input  logic       conv_done,
    input  logic [7:0] conv_out,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_last,
    input  logic       byte_ready,
    output logic [1:0] done,
    output logic       busy,
    output logic [2:0] now
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_LOAD   = 3'd2,
        S_CONV   = 3'd3,
        S_WAITC  = 3'd4,
        S_EMIT   = 3'd5,
        S_FIN    = 3'd6,
        S_UNUSED = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_BOUND - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(ITER_BOUND);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [9:0]       conv_a_q, conv_a_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             byte_valid_q, byte_valid_d;
    logic [1:0]       grp_rd_c, done_c;
    logic             conv_start_c;
    logic             owner_req, in_job, win;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        conv_a_d     = conv_a_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        grp_rd_c     = 2'b00;
        done_c       = 2'b00;
        conv_start_c = 1'b0;
        win          = ~last_q;
        cnt_inc      = cnt_q + CNT_W'(1);
        owner_req    = |(req & gnt_q);
        in_job       = (state_q == S_LOAD) || (state_q == S_CONV) ||
                       (state_q == S_WAITC) || (state_q == S_EMIT);

        // Owner withdrew its request: drop the job silently, but it still
        // counts as served so the other requester gets the next turn.
        if (in_job && !owner_req) begin
            state_d      = S_IDLE;
            byte_valid_d = 1'b0;
            gnt_d        = 2'b00;
            cnt_d        = '0;
            last_d       = gnt_q[1];
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req != 2'b00) state_d = S_ARB;
                end
                S_ARB: begin
                    if (req == 2'b11)  win = ~last_q;
                    else if (req[0])   win = 1'b0;
                    else if (req[1])   win = 1'b1;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    grp_rd_c = gnt_q;
                    conv_a_d = gnt_q[1] ? grp1 : grp0;
                    state_d  = S_CONV;
                end
                S_CONV: begin
                    conv_start_c = 1'b1;
                    state_d      = S_WAITC;
                end
                S_WAITC: begin
                    if (conv_done) begin
                        byte_out_d   = conv_out;
                        byte_valid_d = 1'b1;
                        state_d      = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (byte_ready) begin
                        byte_valid_d = 1'b0;
                        cnt_d        = cnt_inc;
                        state_d      = (cnt_inc == CNT_END) ? S_FIN : S_LOAD;
                    end
                end
                S_FIN: begin
                    done_c  = gnt_q;
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'b00;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            conv_a_q     <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            conv_a_q     <= conv_a_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    assign gnt        = gnt_q;
    assign grp_rd     = grp_rd_c;
    assign conv_a     = conv_a_q;
    assign conv_start = conv_start_c;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign byte_last  = byte_valid_q && (cnt_q == CNT_LAST);
    assign done       = done_c;
    assign busy       = (state_q != S_IDLE);
    assign now        = state_q;

endmodule

// File: tb/tb_pack_s3_sched.sv
// Bench for pack_s3_sched: group sources, a converter model and a byte-stream
// scoreboard, driven through single, contention, backpressure, abort and reset jobs.
module tb_pack_s3_sched;

    localparam int ITER = 140;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt, grp_rd, done;
    logic [9:0] grp0, grp1, conv_a;
    logic       conv_start, conv_done, byte_valid, byte_last, busy;
    logic [7:0] conv_out, byte_out;
    logic       byte_ready = 1'b1;
    logic [2:0] now;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    pack_s3_sched #(.ITER_BOUND(ITER), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .grp0(grp0), .grp1(grp1), .grp_rd(grp_rd), .conv_a(conv_a),
        .conv_start(conv_start), .conv_done(conv_done), .conv_out(conv_out),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .done(done), .busy(busy), .now(now)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Group k from requester r: trit i = (7k + 3r + 5i) mod 3, 2 bits per trit.
    function automatic logic [9:0] gen(input int r, input int k);
        logic [9:0] g;
        int t;
        g = '0;
        for (int i = 0; i < 5; i++) begin
            t = (k * 7 + r * 3 + i * 5) % 3;
            g[2*i +: 2] = 2'(t);
        end
        return g;
    endfunction

    function automatic logic [7:0] trit5(input logic [9:0] g);
        int v;
        int w;
        v = 0;
        w = 1;
        for (int i = 0; i < 5; i++) begin
            v = v + int'(g[2*i +: 2]) * w;
            w = w * 3;
        end
        return 8'(v);
    endfunction

    int pc0 = 0;
    int pc1 = 0;
    assign grp0 = gen(0, pc0);
    assign grp1 = gen(1, pc1);

    logic [7:0] expq[$];

    always @(posedge clk) begin
        if (rst) begin
            if (grp_rd[0]) begin
                expq.push_back(trit5(grp0));
                pc0 <= pc0 + 1;
            end
            if (grp_rd[1]) begin
                expq.push_back(trit5(grp1));
                pc1 <= pc1 + 1;
            end
        end
    end

    // Converter model: result after `lat` extra cycles; spur injects a stray done.
    int         lat  = 0;
    int         wctr = 0;
    logic       cd_r;
    logic [7:0] res_r;
    logic       spur = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cd_r  <= 1'b0;
            wctr  <= 0;
            res_r <= 8'h00;
        end else begin
            cd_r <= 1'b0;
            if (conv_start) begin
                res_r <= trit5(conv_a);
                if (lat == 0) cd_r <= 1'b1;
                else wctr <= lat;
            end else if (wctr > 0) begin
                wctr <= wctr - 1;
                if (wctr == 1) cd_r <= 1'b1;
            end
        end
    end

    assign conv_done = cd_r | spur;
    assign conv_out  = spur ? 8'hEE : res_r;

    // Per-cycle scoreboard, sampled mid-low-phase after the stimulus settles.
    int         job_bytes = 0;
    int         ndone[2]  = '{0, 0};
    logic [7:0] fb[2]     = '{8'h00, 8'h00};
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_hold = 1'b0;
    logic [7:0] prev_out   = 8'h00;
    logic [1:0] prev_gnt   = 2'b00;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            if (prev_gnt == 2'b00 && gnt != 2'b00) begin
                expq.delete();
                job_bytes = 0;
            end
            chk("gnt_onehot", 32'($onehot0(gnt)), 1);
            chk("rd_onehot", 32'($onehot0(grp_rd)), 1);
            chk("done_onehot", 32'($onehot0(done)), 1);
            chk("busy", busy, now != 3'd0);
            chk("byte_last", byte_last, byte_valid && (job_bytes == ITER - 1));
            chk("rd_owner", grp_rd & ~gnt, 0);
            chk("rd_while_valid", (grp_rd != 2'b00) && byte_valid, 0);
            if (prev_valid && !prev_ready && prev_hold) begin
                chk("hold_valid", byte_valid, 1);
                chk("hold_data", byte_out, prev_out);
            end
            if (done != 2'b00) begin
                chk("done_bytes", job_bytes, ITER);
                chk("done_owner", done, gnt);
                if (done[0]) ndone[0]++;
                if (done[1]) ndone[1]++;
            end
            if (byte_valid && byte_ready && ((req & gnt) != 2'b00)) begin
                if (expq.size() == 0) begin
                    chk("byte_unexpected", 0, 1);
                end else begin
                    chk("byte_data", byte_out, expq.pop_front());
                    if (job_bytes < 2) fb[job_bytes] = byte_out;
                    job_bytes++;
                end
            end
            prev_valid = byte_valid;
            prev_ready = byte_ready;
            prev_hold  = (req & gnt) != 2'b00;
            prev_out   = byte_out;
            prev_gnt   = gnt;
        end else begin
            prev_valid = 1'b0;
            prev_gnt   = 2'b00;
            job_bytes  = 0;
            expq.delete();
        end
    end

    task automatic wait_done(input int r, input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done[r]) return;
        end
        chk("timeout_done", 0, 1);
    endtask

    task automatic wait_load(input int budget, output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (now == 3'd2) begin
                g = gnt;
                return;
            end
        end
        chk("timeout_load", 0, 1);
    endtask

    task automatic wait_at(input int nbytes, input logic [2:0] st, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (job_bytes == nbytes && now == st) return;
        end
        chk("timeout_at", 0, 1);
    endtask

    initial begin
        int         cyc;
        int         saved_done;
        logic [1:0] g;
        logic [7:0] saved;

        repeat (3) @(negedge clk);
        chk("reset_state", now, 0);
        chk("reset_ctrl", {gnt, grp_rd, conv_start, done, byte_valid, byte_last, busy}, 0);
        chk("reset_data", {conv_a, byte_out}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", now, 0);

        // Single job from requester 0
        req = 2'b01;
        wait_done(0, 700, cyc);
        req = 2'b00;
        chk("single_cycles", cyc, 562);
        chk("single_first_byte", fb[0], 177);
        chk("single_second_byte", fb[1], 46);
        repeat (3) @(negedge clk);
        chk("single_done_once", ndone[0], 1);

        // Contention from reset, with backpressure and stray conv_done in job 0
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req = 2'b11;
        wait_load(10, g);
        chk("cont_first", g, 2'b01);
        wait_at(10, 3'd5, 200);
        byte_ready = 1'b0;
        saved = byte_out;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            spur = (i == 2);
        end
        spur = 1'b0;
        chk("bp_state", now, 5);
        chk("bp_data", byte_out, saved);
        chk("bp_count", job_bytes, 10);
        byte_ready = 1'b1;
        wait_load(10, g);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_load_next", now, 3);
        chk("spur_load_valid", byte_valid, 0);
        wait_done(0, 700, cyc);
        req = 2'b10;
        wait_load(10, g);
        chk("cont_second", g, 2'b10);
        wait_done(1, 700, cyc);
        req = 2'b11;
        wait_load(10, g);
        chk("cont_third", g, 2'b01);

        // Abort requester 0 while waiting on byte 50; requester 1 still pending
        lat = 2;
        wait_at(49, 3'd4, 800);
        saved_done = ndone[0];
        req = 2'b10;
        @(negedge clk);
        chk("abort_idle", now, 0);
        chk("abort_valid", byte_valid, 0);
        chk("abort_gnt", gnt, 0);
        wait_load(10, g);
        chk("abort_next", g, 2'b10);
        chk("abort_no_done", ndone[0], saved_done);

        // Asynchronous reset in the middle of an EMIT
        lat = 0;
        wait_at(20, 3'd4, 400);
        byte_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_emit", now, 5);
        #3;
        rst = 1'b0;
        #1;
        chk("areset_state", now, 0);
        chk("areset_ctrl", {gnt, grp_rd, conv_start, done, byte_valid, byte_last, busy}, 0);
        chk("areset_data", {conv_a, byte_out}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 2'b10;
        byte_ready = 1'b1;
        wait_load(10, g);
        chk("rst_job_gnt", g, 2'b10);
        wait_done(1, 700, cyc);
        req = 2'b00;
        chk("rst_job_cycles", cyc, 560);
        repeat (3) @(negedge clk);
        chk("ndone0_total", ndone[0], 2);
        chk("ndone1_total", ndone[1], 2);
        chk("final_idle", now, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
